dmem_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single-port data memory among the tinyGPU cores. Each core issues independent load/store requests over a simple req/ack/rvalid handshake. The block grants one request at a time, drives the memory's write-enable, address and write-data pins, and returns read data to the granted core after the memory's read latency. It sits between the core array and the data memory instance.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_rr_picker.sv | 25 ++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
package dmem_arbiter_pkg;

   localparam int unsigned ADDR_W      = 16;
   localparam int unsigned DATA_W      = 16;
   localparam int unsigned DMEM_RD_LAT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin picker: priority starts at ptr+1 and wraps.
module rr_picker #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic          valid_o,
   output logic [PW-1:0] idx_o
);

   logic [PW-1:0] cand;

   // Scan from lowest to highest priority so the last hit is the winner.
   always_comb begin
      valid_o = |req_i;
      idx_o   = '0;
      cand    = '0;
      for (int unsigned k = N; k >= 1; k--) begin
         cand = PW'((32'(ptr_i) + k) % N);
         if (req_i[cand]) idx_o = cand;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data memory among cores.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned N_CORES = 4,
   parameter int unsigned AW      = ADDR_W,
   parameter int unsigned DW      = DATA_W,
   parameter int unsigned RD_LAT  = DMEM_RD_LAT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CORES-1:0]    req,
   input  logic [N_CORES-1:0]    we,
   input  logic [N_CORES*AW-1:0] addr,
   input  logic [N_CORES*DW-1:0] wdata,
   output logic [N_CORES-1:0]    ack,
   output logic [N_CORES-1:0]    rvalid,
   output logic [DW-1:0]         rdata,
   output logic                  mem_wren,
   output logic [AW-1:0]         mem_addr,
   output logic [DW-1:0]         mem_din,
   input  logic [DW-1:0]         mem_q
);

   localparam int unsigned PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int unsigned CW = $clog2(RD_LAT + 1);

   arb_state_e           state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [PW-1:0]        idx_q, idx_d;
   logic                 we_q, we_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [DW-1:0]        wdata_q, wdata_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DW-1:0]        rdata_q, rdata_d;
   logic [N_CORES-1:0]   rvalid_q, rvalid_d;

   logic                 pick_valid;
   logic [PW-1:0]        pick_idx;

   rr_picker #(
      .N  (N_CORES),
      .PW (PW)
   ) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // State and datapath registers; everything clears on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= PW'(N_CORES - 1);
         idx_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Next-state: grant in IDLE, one ISSUE cycle, then RD_LAT WAIT cycles for loads.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      rdata_d  = rdata_q;
      rvalid_d = '0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = ISSUE;
               ptr_d   = pick_idx;
               idx_d   = pick_idx;
               we_d    = we[pick_idx];
               addr_d  = addr[32'(pick_idx) * AW +: AW];
               wdata_d = wdata[32'(pick_idx) * DW +: DW];
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
               cnt_d   = CW'(RD_LAT);
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d          = IDLE;
               rdata_d          = mem_q;
               rvalid_d[idx_q]  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Ack decode is purely from registered state, so req never reaches it combinationally.
   always_comb begin
      ack = '0;
      if (state_q == ISSUE) ack[idx_q] = 1'b1;
   end

   assign mem_wren = (state_q == ISSUE) && we_q;
   assign mem_addr = addr_q;
   assign mem_din  = wdata_q;
   assign rvalid   = rvalid_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model plus directed checks.
module tb_dmem_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned RL = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [N-1:0]      req, we, ack, rvalid;
   logic [N*AW-1:0]   addr;
   logic [N*DW-1:0]   wdata;
   logic [DW-1:0]     rdata, mem_din, mem_q;
   logic              mem_wren;
   logic [AW-1:0]     mem_addr;

   dmem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW), .RD_LAT(RL)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rvalid(rvalid), .rdata(rdata), .mem_wren(mem_wren),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_q(mem_q)
   );

   // Data memory with RL-cycle read latency.
   logic          mem_load;
   logic [DW-1:0] dmem  [0:31];
   logic [DW-1:0] qpipe [0:RL-1];
   always @(posedge clk) begin
      if (mem_load) begin
         for (int a = 0; a < 32; a++) dmem[a] <= 16'h1000 + 16'(a);
      end else if (mem_wren) begin
         dmem[mem_addr[4:0]] <= mem_din;
      end
      qpipe[0] <= dmem[mem_addr[4:0]];
      for (int s = 1; s < RL; s++) qpipe[s] <= qpipe[s-1];
   end
   assign mem_q = qpipe[RL-1];

   // Second instance with a 3-cycle memory.
   logic            rst3;
   logic [N-1:0]    req3, we3, ack3, rvalid3;
   logic [N*AW-1:0] addr3;
   logic [N*DW-1:0] wdata3;
   logic [DW-1:0]   rdata3, din3, q3;
   logic            wren3;
   logic [AW-1:0]   maddr3;

   dmem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst3), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
      .ack(ack3), .rvalid(rvalid3), .rdata(rdata3), .mem_wren(wren3),
      .mem_addr(maddr3), .mem_din(din3), .mem_q(q3)
   );

   logic [DW-1:0] dmem3 [0:31];
   logic [DW-1:0] qp3   [0:2];
   always @(posedge clk) begin
      if (mem_load) begin
         for (int a = 0; a < 32; a++) dmem3[a] <= 16'h2000 + 16'(a);
         dmem3[5] <= 16'h1234;
      end else if (wren3) begin
         dmem3[maddr3[4:0]] <= din3;
      end
      qp3[0] <= dmem3[maddr3[4:0]];
      qp3[1] <= qp3[0];
      qp3[2] <= qp3[1];
   end
   assign q3 = qp3[2];

   // Counters and checker.
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Per-core request queues driven by simple requester agents.
   typedef struct packed {
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
   } op_t;
   op_t opq [N][$];

   task automatic push_op(input int c, input logic w, input logic [15:0] a, input logic [15:0] d);
      op_t o;
      o.w = w; o.a = a; o.d = d;
      opq[c].push_back(o);
   endtask

   // Reference model: one transaction at a time, timing from arithmetic on cycle numbers.
   int unsigned cyc;
   int unsigned free_t, m_ptr;
   int unsigned ack_cyc, ack_idx, rv_cyc, rv_idx;
   logic        ack_we;
   logic [15:0] ack_addr, ack_din, rv_data;
   logic [15:0] disp_addr, disp_din, disp_rdata;
   logic [15:0] ref_mem [0:31];
   logic [N-1:0] busy;
   int unsigned m_ack_at [N];
   int unsigned wait_until [N];
   int unsigned req_cyc [N];
   logic        rst_cmd;

   // Observations of the DUT used by directed checks.
   int unsigned d_ack_cyc [N];
   int unsigned d_rv_cyc  [N];
   logic        d_ack_wren [N];
   logic [15:0] d_ack_addr [N];
   logic [15:0] d_rv_data  [N];
   int unsigned rv_count   [N];
   int unsigned ack_log [$];
   int unsigned wren_log [$];
   logic        rl3_done;

   task automatic model_reset();
      m_ptr = N - 1;
      free_t = 0; ack_cyc = 0; rv_cyc = 0;
      disp_addr = '0; disp_din = '0; disp_rdata = '0;
      busy = '0;
      req  = '0;
      for (int i = 0; i < N; i++) begin
         m_ack_at[i] = 0;
         wait_until[i] = 0;
      end
   endtask

   task automatic tick();
      logic [N-1:0] exp_ack, exp_rv;
      logic         exp_wren;
      op_t          op;
      int unsigned  w;
      logic         found;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (ack[i]) begin
            d_ack_cyc[i] = cyc; d_ack_wren[i] = mem_wren; d_ack_addr[i] = mem_addr;
            ack_log.push_back(i);
         end
         if (rvalid[i]) begin
            d_rv_cyc[i] = cyc; d_rv_data[i] = rdata; rv_count[i]++;
         end
      end
      if (mem_wren) wren_log.push_back(cyc);

      exp_ack = '0; exp_rv = '0; exp_wren = 1'b0;
      if (!rst && cyc == ack_cyc) begin
         exp_ack[ack_idx] = 1'b1;
         exp_wren = ack_we;
         disp_addr = ack_addr;
         disp_din  = ack_din;
      end
      if (!rst && cyc == rv_cyc) begin
         exp_rv[rv_idx] = 1'b1;
         disp_rdata = rv_data;
      end
      chk("ack", ack, exp_ack);
      chk("rvalid", rvalid, exp_rv);
      chk("mem_wren", mem_wren, exp_wren);
      chk("mem_addr", mem_addr, disp_addr);
      chk("mem_din", mem_din, disp_din);
      chk("rdata", rdata, disp_rdata);

      rst = rst_cmd;
      if (rst) model_reset();

      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            if (busy[i] && cyc == m_ack_at[i] + 1) begin
               busy[i] = 1'b0;
               req[i]  = 1'b0;
            end
            if (!busy[i] && cyc > wait_until[i] && opq[i].size() > 0) begin
               op = opq[i].pop_front();
               busy[i] = 1'b1;
               req[i]  = 1'b1;
               we[i]   = op.w;
               addr[i*AW +: AW]  = op.a;
               wdata[i*DW +: DW] = op.d;
               req_cyc[i] = cyc;
            end
         end
      end

      if (!rst && cyc >= free_t && (|req)) begin
         found = 1'b0; w = 0;
         for (int k = 1; k <= N; k++) begin
            if (!found && req[(m_ptr + k) % N]) begin
               w = (m_ptr + k) % N;
               found = 1'b1;
            end
         end
         m_ptr    = w;
         ack_cyc  = cyc + 1;
         ack_idx  = w;
         ack_we   = we[w];
         ack_addr = addr[w*AW +: AW];
         ack_din  = wdata[w*DW +: DW];
         m_ack_at[w] = cyc + 1;
         if (ack_we) begin
            ref_mem[ack_addr[4:0]] = ack_din;
            free_t = cyc + 2;
            wait_until[w] = 0;
         end else begin
            rv_cyc  = cyc + 2 + RL;
            rv_idx  = w;
            rv_data = ref_mem[ack_addr[4:0]];
            free_t  = rv_cyc;
            wait_until[w] = rv_cyc;
         end
      end
   endtask

   function automatic logic is_idle();
      logic r;
      r = (busy == '0) && (cyc >= free_t);
      for (int i = 0; i < N; i++) if (opq[i].size() != 0 || cyc <= wait_until[i]) r = 1'b0;
      return r;
   endfunction

   task automatic wait_idle(input string nm);
      int unsigned n;
      n = 0;
      while (!is_idle() && n < 400) begin
         tick();
         n++;
      end
      chk(nm, is_idle(), 1'b1);
      tick();
   endtask

   task automatic do_reset_mid();
      rst = 1'b1;
      rst_cmd = 1'b1;
      #1;
      chk("rst_ack", ack, '0);
      chk("rst_rvalid", rvalid, '0);
      chk("rst_wren", mem_wren, 1'b0);
      chk("rst_addr", mem_addr, '0);
      chk("rst_din", mem_din, '0);
      chk("rst_rdata", rdata, '0);
      model_reset();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Main sequence.
   initial begin
      int unsigned n, rv_before;
      rst = 1'b1; rst_cmd = 1'b1; mem_load = 1'b1;
      req = '0; we = '0; addr = '0; wdata = '0; cyc = 0;
      for (int a = 0; a < 32; a++) ref_mem[a] = 16'h1000 + 16'(a);
      for (int i = 0; i < N; i++) begin
         d_ack_cyc[i] = 0; d_rv_cyc[i] = 0; d_ack_wren[i] = 1'b0;
         d_ack_addr[i] = '0; d_rv_data[i] = '0; rv_count[i] = 0; req_cyc[i] = 0;
      end
      model_reset();
      repeat (3) tick();
      mem_load = 1'b0;
      chk("reset_ack", ack, '0);
      chk("reset_wren", mem_wren, 1'b0);
      chk("reset_rdata", rdata, '0);

      // First grant after reset goes to core 0 even with core 3 competing.
      rst_cmd = 1'b0;
      ack_log.delete();
      push_op(3, 1'b1, 16'h0003, 16'h3333);
      push_op(0, 1'b1, 16'h0004, 16'h4444);
      wait_idle("idle_first");
      chk("first_grant", (ack_log.size() > 0) ? ack_log[0] : 99, 0);

      // Core 2 store then load.
      push_op(2, 1'b1, 16'h0010, 16'hBEEF);
      wait_idle("idle_st");
      chk("st_ack_lat", d_ack_cyc[2] - req_cyc[2], 1);
      chk("st_ack_wren", d_ack_wren[2], 1'b1);
      chk("st_ack_addr", d_ack_addr[2], 16'h0010);
      push_op(2, 1'b0, 16'h0010, 16'h0000);
      wait_idle("idle_ld");
      chk("ld_ack_wren", d_ack_wren[2], 1'b0);
      chk("ld_rv_lat", d_rv_cyc[2] - req_cyc[2], 3);
      chk("ld_rdata", d_rv_data[2], 16'hBEEF);

      // Back-to-back stores from core 1.
      wren_log.delete();
      for (int a = 0; a < 8; a++) push_op(1, 1'b1, 16'(a), 16'(a + 1));
      wait_idle("idle_b2b");
      chk("b2b_count", wren_log.size(), 8);
      for (int k = 1; k < 8 && k < wren_log.size(); k++) chk("b2b_gap", wren_log[k] - wren_log[k-1], 2);
      for (int a = 0; a < 8; a++) chk("b2b_mem", dmem[a], 16'(a + 1));

      // Fairness with all cores loading continuously, starting from reset.
      do_reset_mid();
      repeat (2) tick();
      rst_cmd = 1'b0;
      ack_log.delete();
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < N; i++) push_op(i, 1'b0, 16'($urandom_range(0, 31)), 16'h0000);
      wait_idle("idle_fair");
      chk("fair_count", ack_log.size(), 12);
      for (int k = 0; k < 12 && k < ack_log.size(); k++) chk("fair_order", ack_log[k], k % 4);

      // Reset one cycle after the ack of a load.
      push_op(3, 1'b0, 16'h0007, 16'h0000);
      n = 0;
      tick();
      while (cyc != m_ack_at[3] + 1 && n < 50) begin
         tick();
         n++;
      end
      chk("wait_reached", cyc == m_ack_at[3] + 1, 1'b1);
      rv_before = rv_count[3];
      do_reset_mid();
      repeat (4) tick();
      rst_cmd = 1'b0;
      repeat (4) tick();
      chk("aborted_no_rv", rv_count[3], rv_before);
      push_op(3, 1'b0, 16'h0008, 16'h0000);
      wait_idle("idle_after_abort");
      chk("post_abort_lat", d_rv_cyc[3] - req_cyc[3], 3);
      chk("post_abort_data", d_rv_data[3], 16'h1008);

      // Randomized traffic against the reference model.
      repeat (1500) begin
         for (int i = 0; i < N; i++) begin
            if (opq[i].size() == 0 && $urandom_range(0, 2) == 0)
               push_op(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
         end
         tick();
      end
      wait_idle("idle_rand");

      n = 0;
      while (!rl3_done && n < 200) begin
         tick();
         n++;
      end
      chk("rl3_done", rl3_done, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Three-cycle read latency instance: core 0 load, core 1 arriving during ISSUE.
   initial begin
      int unsigned a0, a1, r0;
      logic [15:0] rd0;
      rst3 = 1'b1; req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0; rl3_done = 1'b0;
      a0 = 100; a1 = 100; r0 = 100; rd0 = '0;
      repeat (5) @(posedge clk);
      #1;
      rst3 = 1'b0;
      @(posedge clk);
      #1;
      req3[0] = 1'b1; we3[0] = 1'b0; addr3[0 +: AW] = 16'h0005;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         if (ack3[0]) a0 = k;
         if (ack3[1]) a1 = k;
         if (rvalid3[0]) begin
            r0 = k; rd0 = rdata3;
         end
         if (k == 1) begin
            req3[1] = 1'b1; we3[1] = 1'b0; addr3[AW +: AW] = 16'h0006;
         end
         if (k == a0 + 1) req3[0] = 1'b0;
         if (k == a1 + 1) req3[1] = 1'b0;
      end
      chk("rl3_ack0", a0, 1);
      chk("rl3_rv0", r0, 5);
      chk("rl3_rdata", rd0, 16'h1234);
      chk("rl3_ack1", a1, 6);
      rl3_done = 1'b1;
   end

endmodule
